burst_grant_forwarder: RTL and testbench

BURST_GRANT_FORWARDER -- requirements
Module: burst_grant_forwarder

---
 rtl/burst_grant_forwarder.sv | 161 ++++++++++++++++
 tb/tb_burst_grant_forwarder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_grant_forwarder.sv
// burst_grant_forwarder
//   Locks onto the port chosen by an upstream arbiter and forwards that port's
//   beat stream downstream until a last beat transfers. A burst is forcibly
//   ended on beat MaxBurst (out_last raised by the beat counter).
//
// Optional feature (compile-time macro): BURST_TIMEOUT_EN
//   When defined, a burst whose owner presents no valid beat for StallLimit
//   consecutive LOCKED cycles is released without emitting a beat.
//
// Ports
//   clk        : clock, all state changes on rising edge
//   rst        : synchronous active-high reset
//   grant      : one-hot grant from upstream arbiter
//   select     : granted index from upstream arbiter
//   req_valid  : per-port beat valid
//   req_data   : per-port payload, port i at [i*DataWidth +: DataWidth]
//   req_last   : per-port final-beat flag
//   req_ready  : per-port beat accept
//   out_valid  : forwarded beat valid
//   out_data   : forwarded payload
//   out_last   : forwarded final-beat flag (natural or forced)
//   out_ready  : downstream accept
//   busy       : high while a burst is locked
//   owner      : registered index of the locked port
module burst_grant_forwarder #(
    parameter int NumRequests = 4,
    parameter int DataWidth   = 8,
    parameter int MaxBurst    = 16,
    parameter int StallLimit  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NumRequests-1:0]           grant,
    input  logic [$clog2(NumRequests):0]     select,
    input  logic [NumRequests-1:0]           req_valid,
    input  logic [NumRequests*DataWidth-1:0] req_data,
    input  logic [NumRequests-1:0]           req_last,
    output logic [NumRequests-1:0]           req_ready,
    output logic                             out_valid,
    output logic [DataWidth-1:0]             out_data,
    output logic                             out_last,
    input  logic                             out_ready,
    output logic                             busy,
    output logic [$clog2(NumRequests):0]     owner
);

    localparam int SW = $clog2(NumRequests) + 1;
    // Beat counter is at least 8 bits wide, wider if MaxBurst needs it.
    localparam int CW = (($clog2(MaxBurst) + 1) > 8) ? ($clog2(MaxBurst) + 1) : 8;

    if (MaxBurst < 2 || StallLimit < 1) begin : g_param_check
        $error("burst_grant_forwarder: MaxBurst must be >= 2 and StallLimit >= 1");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t              state, state_nxt;
    logic [SW-1:0]       owner_nxt;
    logic [CW-1:0]       beat_cnt, beat_cnt_nxt;
    logic                sel_valid;
    logic                sel_last;
    logic [DataWidth-1:0] sel_data;
    logic                forced_last;

`ifdef BURST_TIMEOUT_EN
    localparam int TW = $clog2(StallLimit + 1);
    logic [TW-1:0]       stall_cnt, stall_cnt_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            beat_cnt <= '0;
`ifdef BURST_TIMEOUT_EN
            stall_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_cnt_nxt;
`ifdef BURST_TIMEOUT_EN
            stall_cnt <= stall_cnt_nxt;
`endif
        end
    end

    always_comb begin
        // Owner-port mux; owner is always in range while LOCKED.
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NumRequests; i++) begin
            if (owner == SW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DataWidth +: DataWidth];
            end
        end
        forced_last = (beat_cnt == CW'(MaxBurst - 1));

        state_nxt    = state;
        owner_nxt    = owner;
        beat_cnt_nxt = beat_cnt;
`ifdef BURST_TIMEOUT_EN
        stall_cnt_nxt = stall_cnt;
`endif
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;

        case (state)
            IDLE: begin
                if (|grant && (select < SW'(NumRequests))) begin
                    state_nxt    = LOCKED;
                    owner_nxt    = select;
                    beat_cnt_nxt = '0;
`ifdef BURST_TIMEOUT_EN
                    stall_cnt_nxt = '0;
`endif
                end
            end
            LOCKED: begin
                busy      = 1'b1;
                out_valid = sel_valid;
                out_data  = sel_data;
                out_last  = sel_last | forced_last;
                for (int unsigned i = 0; i < NumRequests; i++) begin
                    if (owner == SW'(i)) begin
                        req_ready[i] = out_ready;
                    end
                end
                if (sel_valid && out_ready) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    // Natural and forced last share this one release path.
                    if (out_last) begin
                        state_nxt = IDLE;
                    end
                end
`ifdef BURST_TIMEOUT_EN
                // A stalled cycle never transfers, so releasing here drops no beat.
                if (sel_valid) begin
                    stall_cnt_nxt = '0;
                end else begin
                    stall_cnt_nxt = stall_cnt + 1'b1;
                    if (stall_cnt_nxt == TW'(StallLimit)) begin
                        state_nxt = IDLE;
                    end
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_burst_grant_forwarder.sv
// Directed testbench for burst_grant_forwarder with a beat scoreboard.
// Stimulus pushes each expected beat {last,data}; the monitor pops and
// compares whenever a beat transfers (out_valid && out_ready).
module tb_burst_grant_forwarder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int SL = 8;
    localparam int SW = $clog2(N) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    grant;
    logic [SW-1:0]   select;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic            busy;
    logic [SW-1:0]   owner;

    always #5 clk = ~clk;

    burst_grant_forwarder #(
        .NumRequests(N),
        .DataWidth  (DW),
        .MaxBurst   (MB),
        .StallLimit (SL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .grant    (grant),
        .select   (select),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .busy     (busy),
        .owner    (owner)
    );

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic beat(input int p, input logic [7:0] d, input logic l);
        req_valid[p]          = 1'b1;
        req_data[p*DW +: DW]  = d;
        req_last[p]           = l;
    endtask

    task automatic expect_beat(input logic l, input logic [7:0] d);
        exp_q.push_back({l, d});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat",
                         out_data, out_last);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", 32'(out_data), 32'(mon_e[7:0]));
                chk("beat_last", 32'(out_last), 32'(mon_e[8]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; grant = '0; select = '0; req_valid = '0;
        req_data = '0; req_last = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mid;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        step;
        rst = 1'b0;

        // Test 1: normal 3-beat burst on port 1
        grant = 4'b0010; select = 3'd1;
        step;
        grant = '0; select = '0;
        mid;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_owner", 32'(owner), 1);
        step;
        out_ready = 1'b1;
        beat(1, 8'hA1, 1'b0); expect_beat(1'b0, 8'hA1);
        mid;
        chk("t1_req_ready", 32'(req_ready), 32'b0010);
        step;
        beat(1, 8'hA2, 1'b0); expect_beat(1'b0, 8'hA2);
        step;
        beat(1, 8'hA3, 1'b1); expect_beat(1'b1, 8'hA3);
        mid;
        chk("t1_out_last", 32'(out_last), 1);
        step;
        req_valid = '0; req_last = '0;
        mid;
        chk("t1_busy_drop", 32'(busy), 0);

        // Test 2: forced end at beat MaxBurst on port 0
        grant = 4'b0001; select = 3'd0;
        step;
        grant = '0;
        beat(0, 8'hB0, 1'b0); expect_beat(1'b0, 8'hB0);
        step;
        beat(0, 8'hB1, 1'b0); expect_beat(1'b0, 8'hB1);
        step;
        beat(0, 8'hB2, 1'b0); expect_beat(1'b0, 8'hB2);
        step;
        beat(0, 8'hB3, 1'b0); expect_beat(1'b1, 8'hB3);
        mid;
        chk("t2_forced_last", 32'(out_last), 1);
        step;
        req_valid = '0;
        mid;
        chk("t2_busy_drop", 32'(busy), 0);

        // Test 3: backpressure on port 2 (ready 1,0,0,1,...), forced end on 4th beat
        grant = 4'b0100; select = 3'd2;
        step;
        grant = '0; select = '0;
        out_ready = 1'b1;
        beat(2, 8'hC0, 1'b0); expect_beat(1'b0, 8'hC0);
        step;
        beat(2, 8'hC1, 1'b0);
        out_ready = 1'b0;
        mid;
        chk("t3_stall_valid", 32'(out_valid), 1);
        chk("t3_stall_ready", 32'(req_ready), 0);
        chk("t3_stall_data", 32'(out_data), 32'hC1);
        step;
        mid;
        chk("t3_stall_hold", 32'(out_data), 32'hC1);
        chk("t3_stall_busy", 32'(busy), 1);
        step;
        out_ready = 1'b1; expect_beat(1'b0, 8'hC1);
        mid;
        chk("t3_resume_ready", 32'(req_ready), 32'b0100);
        step;
        beat(2, 8'hC2, 1'b0); expect_beat(1'b0, 8'hC2);
        step;
        beat(2, 8'hC3, 1'b0); expect_beat(1'b1, 8'hC3);
        step;
        req_valid = '0;
        mid;
        chk("t3_busy_drop", 32'(busy), 0);

        // Test 4: invalid grant/select keep the block idle
        req_valid = 4'b1111; grant = '0; select = 3'd1;
        step;
        mid;
        chk("t4_nogrant_busy", 32'(busy), 0);
        chk("t4_nogrant_valid", 32'(out_valid), 0);
        grant = 4'b0001; select = 3'd4;
        step;
        mid;
        chk("t4_badsel_busy", 32'(busy), 0);
        chk("t4_badsel_ready", 32'(req_ready), 0);
        grant = '0; select = '0; req_valid = '0;

        // Test 5: grant moves to port 2 during port 0's burst; no re-lock in release cycle
        grant = 4'b0001; select = 3'd0;
        step;
        grant = 4'b0100; select = 3'd2;
        beat(0, 8'hD0, 1'b0); beat(2, 8'hE0, 1'b0); expect_beat(1'b0, 8'hD0);
        mid;
        chk("t5_owner", 32'(owner), 0);
        chk("t5_req_ready", 32'(req_ready), 32'b0001);
        step;
        beat(0, 8'hD1, 1'b1); expect_beat(1'b1, 8'hD1);
        step;
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
        req_last[2] = 1'b1; expect_beat(1'b1, 8'hE0);
        mid;
        chk("t5_no_relock", 32'(busy), 0);
        chk("t5_release_valid", 32'(out_valid), 0);
        step;
        grant = '0; select = '0;
        mid;
        chk("t5_relock_busy", 32'(busy), 1);
        chk("t5_relock_owner", 32'(owner), 2);
        step;
        req_valid = '0; req_last = '0;
        mid;
        chk("t5_busy_drop", 32'(busy), 0);

        // Test 6: reset during beat 2 aborts the burst
        grant = 4'b0010; select = 3'd1;
        step;
        grant = '0; select = '0;
        beat(1, 8'hF0, 1'b0); expect_beat(1'b0, 8'hF0);
        step;
        beat(1, 8'hF1, 1'b0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        beat(1, 8'hF2, 1'b0);
        mid;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_owner", 32'(owner), 0);
        chk("t6_rst_ready", 32'(req_ready), 0);
        step;
        req_valid = '0;

        // Stall behaviour: owner port 0 presents no beats
        grant = 4'b0001; select = 3'd0;
        step;
        grant = '0;
`ifdef BURST_TIMEOUT_EN
        repeat (SL - 1) step;
        mid;
        chk("t6_stall_hold", 32'(busy), 1);
        step;
        mid;
        chk("t6_timeout_release", 32'(busy), 0);
`else
        repeat (10) step;
        mid;
        chk("t6_no_timeout", 32'(busy), 1);
        step;
        beat(0, 8'h5A, 1'b1); expect_beat(1'b1, 8'h5A);
        step;
        req_valid = '0; req_last = '0;
        mid;
        chk("t6_stall_end", 32'(busy), 0);
`endif

        repeat (3) step;
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
